// File: rtl/smol_boi.sv
// smol_boi: 128 x 8 byte memory behind a mode-0, MSB-first SPI slave link.
// SPI pins are asynchronous and are synchronised onto CLK; all logic runs on CLK.
// Frame layout: RW bit, 7-bit address, turnaround, then write data or read wait + data,
// then one trailing idle edge. Frames run back-to-back while CS stays low.
// Build option: define SMOL_BOI_MISO_TRISTATE_EN to float MISO outside RD_SHIFT;
// otherwise MISO is driven 0 there.
module smol_boi (
    input  logic CLK,
    input  logic RST_N,
    input  logic CS,
    input  logic SCLK,
    input  logic MOSI,
    output logic MISO
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        TURN,
        WR_DATA,
        WR_COMMIT,
        RD_WAIT,
        RD_SHIFT,
        TRAIL
    } state_t;

    logic       csMeta_q;
    logic       csSync_q;
    logic       sclkMeta_q;
    logic       sclkSync_q;
    logic       sclkPrev_q;
    logic       mosiMeta_q;
    logic       mosiSync_q;

    state_t     state_q;
    logic [4:0] edgeCnt_q;
    logic [7:0] cmdShift_q;
    logic [7:0] wrShift_q;
    logic [7:0] rdShift_q;
    logic [3:0] outCnt_q;
    logic       misoBit_q;

    logic [7:0] mem [128];

    logic       sclkRise;
    logic       sclkFall;
    logic [4:0] edgeNext;
    logic [6:0] addr;

    // Two-flop synchronisers; CS resets to its inactive level so no frame starts spuriously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            csMeta_q   <= 1'b1;
            csSync_q   <= 1'b1;
            sclkMeta_q <= 1'b0;
            sclkSync_q <= 1'b0;
            sclkPrev_q <= 1'b0;
            mosiMeta_q <= 1'b0;
            mosiSync_q <= 1'b0;
        end else begin
            csMeta_q   <= CS;
            csSync_q   <= csMeta_q;
            sclkMeta_q <= SCLK;
            sclkSync_q <= sclkMeta_q;
            sclkPrev_q <= sclkSync_q;
            mosiMeta_q <= MOSI;
            mosiSync_q <= mosiMeta_q;
        end
    end

    assign sclkRise = sclkSync_q & ~sclkPrev_q;
    assign sclkFall = ~sclkSync_q & sclkPrev_q;
    assign edgeNext = edgeCnt_q + 5'd1;
    assign addr     = cmdShift_q[6:0];

    // Frame sequencer: counts SCLK rises, shifts command/data in and read data out.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            edgeCnt_q  <= 5'd0;
            cmdShift_q <= 8'd0;
            wrShift_q  <= 8'd0;
            rdShift_q  <= 8'd0;
            outCnt_q   <= 4'd0;
            misoBit_q  <= 1'b0;
        end else if (csSync_q) begin
            state_q    <= IDLE;
            edgeCnt_q  <= 5'd0;
            cmdShift_q <= 8'd0;
            wrShift_q  <= 8'd0;
            rdShift_q  <= 8'd0;
            outCnt_q   <= 4'd0;
            misoBit_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= CMD;
                    if (sclkRise) begin
                        cmdShift_q <= {cmdShift_q[6:0], mosiSync_q};
                        edgeCnt_q  <= edgeNext;
                    end
                end
                CMD: begin
                    if (sclkRise) begin
                        cmdShift_q <= {cmdShift_q[6:0], mosiSync_q};
                        edgeCnt_q  <= edgeNext;
                        if (edgeNext == 5'd8) begin
                            state_q <= TURN;
                        end
                    end
                end
                TURN: begin
                    if (sclkRise) begin
                        edgeCnt_q <= edgeNext;
                        state_q   <= cmdShift_q[7] ? RD_WAIT : WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (sclkRise) begin
                        wrShift_q <= {wrShift_q[6:0], mosiSync_q};
                        edgeCnt_q <= edgeNext;
                        if (edgeNext == 5'd17) begin
                            state_q <= WR_COMMIT;
                        end
                    end
                end
                WR_COMMIT: begin
                    state_q <= TRAIL;
                end
                RD_WAIT: begin
                    if (sclkRise) begin
                        edgeCnt_q <= edgeNext;
                        if (edgeNext == 5'd10) begin
                            rdShift_q <= mem[addr];
                        end
                        if (edgeNext == 5'd11) begin
                            state_q  <= RD_SHIFT;
                            outCnt_q <= 4'd0;
                        end
                    end
                end
                RD_SHIFT: begin
                    if (sclkRise) begin
                        edgeCnt_q <= edgeNext;
                    end
                    if (sclkFall) begin
                        if (outCnt_q != 4'd8) begin
                            misoBit_q <= rdShift_q[7];
                            rdShift_q <= {rdShift_q[6:0], 1'b0};
                            outCnt_q  <= outCnt_q + 4'd1;
                        end else begin
                            misoBit_q <= 1'b0;
                            state_q   <= TRAIL;
                        end
                    end
                end
                TRAIL: begin
                    if (sclkRise) begin
                        edgeCnt_q <= 5'd0;
                        state_q   <= CMD;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory write port; deliberately unreset so contents survive RST_N.
    always_ff @(posedge CLK) begin
        if (state_q == WR_COMMIT && !csSync_q) begin
            mem[addr] <= wrShift_q;
        end
    end

`ifdef SMOL_BOI_MISO_TRISTATE_EN
    assign MISO = (state_q == RD_SHIFT) ? misoBit_q : 1'bz;
`else
    assign MISO = misoBit_q;
`endif

endmodule

// File: tb/tb_smol_boi.sv
// Testbench for smol_boi: directed SPI frames with hand-computed expected bytes.
module tb_smol_boi;

    logic CLK;
    logic RST_N;
    logic CS;
    logic SCLK;
    logic MOSI;
    logic MISO;

    int checks = 0;
    int errors = 0;
    int halfCyc = 5;

`ifdef SMOL_BOI_MISO_TRISTATE_EN
    logic idleLevel = 1'bz;
`else
    logic idleLevel = 1'b0;
`endif

    smol_boi dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CS    (CS),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One full SCLK period: set MOSI, raise SCLK (sampling MISO at the rise), then drop SCLK.
    task automatic sclkEdge(input logic mosiBit, output logic misoAtRise);
        MOSI = mosiBit;
        repeat (halfCyc) @(posedge CLK);
        #2;
        SCLK = 1'b1;
        misoAtRise = MISO;
        repeat (halfCyc) @(posedge CLK);
        #2;
        SCLK = 1'b0;
    endtask

    task automatic doWrite(input logic [6:0] addr, input logic [7:0] data);
        logic [7:0] cmd;
        logic b;
        cmd = {1'b0, addr};
        for (int i = 7; i >= 0; i--) sclkEdge(cmd[i], b);
        sclkEdge(1'b0, b);
        for (int i = 7; i >= 0; i--) sclkEdge(data[i], b);
        sclkEdge(1'b0, b);
    endtask

    task automatic doRead(input logic [6:0] addr, output logic [7:0] data, output logic after);
        logic [7:0] cmd;
        logic b;
        cmd = {1'b1, addr};
        for (int i = 7; i >= 0; i--) sclkEdge(cmd[i], b);
        sclkEdge(1'b0, b);
        sclkEdge(1'b0, b);
        sclkEdge(1'b0, b);
        for (int i = 7; i >= 0; i--) begin
            sclkEdge(1'b0, b);
            data[i] = b;
        end
        sclkEdge(1'b0, b);
        after = b;
    endtask

    task automatic test_reset;
        CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; RST_N = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        checks++;
        if (MISO !== idleLevel) begin
            errors++;
            $display("[TB] FAIL reset_miso: got %b expected %b", MISO, idleLevel);
        end
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        CS = 1'b0;
        repeat (4) @(posedge CLK);
    endtask

    task automatic test_write_read;
        logic [7:0] d;
        logic after;
        doWrite(7'h55, 8'h33);
        doRead(7'h55, d, after);
        checks++;
        if (d !== 8'h33) begin
            errors++;
            $display("[TB] FAIL rd_55: got %h expected 33", d);
        end
        checks++;
        if (after !== idleLevel) begin
            errors++;
            $display("[TB] FAIL rd_55_idle: got %b expected %b", after, idleLevel);
        end
    endtask

    task automatic test_addr_wrap;
        logic [7:0] d;
        logic after;
        doWrite(7'h00, 8'hA5);
        doWrite(7'h7F, 8'h5A);
        doRead(7'h00, d, after);
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL rd_00: got %h expected a5", d);
        end
        doRead(7'h7F, d, after);
        checks++;
        if (d !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL rd_7f: got %h expected 5a", d);
        end
        checks++;
        if (after !== idleLevel) begin
            errors++;
            $display("[TB] FAIL rd_7f_idle: got %b expected %b", after, idleLevel);
        end
    endtask

    task automatic test_abort;
        logic [7:0] cmd;
        logic [7:0] d;
        logic b;
        logic after;
        cmd = 8'h55;
        for (int i = 7; i >= 0; i--) sclkEdge(cmd[i], b);
        sclkEdge(1'b0, b);
        for (int i = 0; i < 5; i++) sclkEdge(1'b1, b);
        CS = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        checks++;
        if (MISO !== idleLevel) begin
            errors++;
            $display("[TB] FAIL abort_miso: got %b expected %b", MISO, idleLevel);
        end
        CS = 1'b0;
        repeat (6) @(posedge CLK);
        doRead(7'h55, d, after);
        checks++;
        if (d !== 8'h33) begin
            errors++;
            $display("[TB] FAIL abort_rd_55: got %h expected 33", d);
        end
    endtask

    task automatic test_reset_midread;
        logic [7:0] cmd;
        logic [3:0] hi;
        logic [7:0] d;
        logic b;
        logic after;
        cmd = 8'hD5;
        for (int i = 7; i >= 0; i--) sclkEdge(cmd[i], b);
        for (int i = 0; i < 3; i++) sclkEdge(1'b0, b);
        for (int i = 3; i >= 0; i--) begin
            sclkEdge(1'b0, b);
            hi[i] = b;
        end
        checks++;
        if (hi !== 4'h3) begin
            errors++;
            $display("[TB] FAIL midread_hi: got %h expected 3", hi);
        end
        RST_N = 1'b0;
        #2;
        checks++;
        if (MISO !== idleLevel) begin
            errors++;
            $display("[TB] FAIL midread_reset_miso: got %b expected %b", MISO, idleLevel);
        end
        CS = 1'b1;
        repeat (5) @(posedge CLK);
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        CS = 1'b0;
        repeat (4) @(posedge CLK);
        doRead(7'h55, d, after);
        checks++;
        if (d !== 8'h33) begin
            errors++;
            $display("[TB] FAIL post_reset_rd_55: got %h expected 33", d);
        end
    endtask

    task automatic test_idle_toggle;
        logic b;
        logic [7:0] d;
        logic after;
        CS = 1'b1;
        repeat (6) @(posedge CLK);
        for (int i = 0; i < 20; i++) begin
            sclkEdge(1'b0, b);
            checks++;
            if (b !== idleLevel) begin
                errors++;
                $display("[TB] FAIL idle_miso edge %0d: got %b expected %b", i + 1, b, idleLevel);
            end
        end
        CS = 1'b0;
        repeat (6) @(posedge CLK);
        doRead(7'h00, d, after);
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL idle_rd_00: got %h expected a5", d);
        end
        doRead(7'h55, d, after);
        checks++;
        if (d !== 8'h33) begin
            errors++;
            $display("[TB] FAIL idle_rd_55: got %h expected 33", d);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic after;
        halfCyc = 4;
        doWrite(7'h12, 8'hC3);
        doRead(7'h12, d, after);
        checks++;
        if (d !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL b2b_rd_12: got %h expected c3", d);
        end
        checks++;
        if (after !== idleLevel) begin
            errors++;
            $display("[TB] FAIL b2b_idle: got %b expected %b", after, idleLevel);
        end
        doRead(7'h7F, d, after);
        checks++;
        if (d !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL b2b_rd_7f: got %h expected 5a", d);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_addr_wrap();
        test_abort();
        test_reset_midread();
        test_idle_toggle();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
